// File: rtl/lsu_pkg.sv
// Purpose: shared constants, FSM state type and request-check helpers for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: WIDTH_DEFAULT, RV32I funct3 codes, lsu_state_t, f3_illegal(), f3_misaligned().
package lsu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WR,
    RESP
  } lsu_state_t;

  // 011 and 11x are not RV32I load/store widths; stores have no unsigned forms.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    return ((f3[1:0] == 2'b01) && addr_lo[0]) ||
           ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purpose: load byte/half/word select with sign/zero extension, and SB/SH byte merge into a read word.
// Latency: combinational.
// Backpressure: none.
// Ports: i_funct3 access code, i_rd RAM read word, i_wdata low store data,
//        o_load extended load value, o_merge read word with byte 0 or bytes 1:0 replaced.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_rd,
  input  logic [15:0]      i_wdata,
  output logic [WIDTH-1:0] o_load,
  output logic [WIDTH-1:0] o_merge
);

  // funct3[2] set means unsigned: suppress the sign fill.
  logic w_sign_b;
  logic w_sign_h;

  assign w_sign_b = ~i_funct3[2] & i_rd[7];
  assign w_sign_h = ~i_funct3[2] & i_rd[15];

  always_comb begin
    o_load = i_rd;
    case (i_funct3[1:0])
      2'b00:   o_load = {{(WIDTH-8){w_sign_b}}, i_rd[7:0]};
      2'b01:   o_load = {{(WIDTH-16){w_sign_h}}, i_rd[15:0]};
      default: o_load = i_rd;
    endcase
  end

  always_comb begin
    o_merge = i_rd;
    if (i_funct3[1:0] == 2'b00) begin
      o_merge[7:0] = i_wdata[7:0];
    end else begin
      o_merge[15:0] = i_wdata[15:0];
    end
  end

endmodule

// File: rtl/lsu_rmw.sv
// Purpose: RV32I load/store unit driving a 32-bit word RAM; SB/SH done as read-modify-write.
// Latency: response 1 cycle after accept for errors, 2 for loads/SW, 3 for SB/SH.
// Backpressure: req_ready_o high only in IDLE; one request in flight at a time.
// Ports: req_* request handshake, resp_* one-cycle response pulse, ram_* word RAM port (combinational read).
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into error responses.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             resp_valid_o,
  output logic [WIDTH-1:0] resp_rdata_o,
  output logic             resp_err_o,
  output logic             ram_we_o,
  output logic [WIDTH-1:0] ram_a_o,
  output logic [WIDTH-1:0] ram_wd_o,
  input  logic [WIDTH-1:0] ram_rd_i
);

  lsu_state_t       r_state;
  logic [2:0]       r_funct3;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_wd;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;
  logic             r_resp_vld;
  logic             r_ram_we;
  logic             r_ready;

  logic             w_err;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_merge;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_err = f3_illegal(req_we_i, req_funct3_i) ||
                 f3_misaligned(req_funct3_i, req_addr_i[1:0]);
`else
  assign w_err = f3_illegal(req_we_i, req_funct3_i);
`endif

  lsu_align #(
    .WIDTH (WIDTH)
  ) u_align (
    .i_funct3 (r_funct3),
    .i_rd     (ram_rd_i),
    .i_wdata  (r_wdata[15:0]),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  // All outputs are registered alongside the state so they change only on an edge
  // (or immediately on reset).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wd       <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_resp_vld <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp_vld <= 1'b0;
          if (req_valid_i) begin
            r_funct3 <= req_funct3_i;
            r_addr   <= req_addr_i;
            r_wdata  <= req_wdata_i;
            // SW writes the store data directly; RMW overwrites this with the merge word.
            r_wd     <= req_wdata_i;
            r_rdata  <= '0;
            r_err    <= w_err;
            r_ready  <= 1'b0;
            if (w_err) begin
              r_state    <= RESP;
              r_resp_vld <= 1'b1;
            end else if (!req_we_i) begin
              r_state <= LOAD;
            end else if (req_funct3_i == F3_W) begin
              r_state  <= WR;
              r_ram_we <= 1'b1;
            end else begin
              r_state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          r_rdata    <= w_load;
          r_state    <= RESP;
          r_resp_vld <= 1'b1;
        end
        RMW_RD: begin
          r_wd     <= w_merge;
          r_ram_we <= 1'b1;
          r_state  <= WR;
        end
        WR: begin
          r_ram_we   <= 1'b0;
          r_state    <= RESP;
          r_resp_vld <= 1'b1;
        end
        RESP: begin
          r_resp_vld <= 1'b0;
          r_ready    <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_resp_vld <= 1'b0;
          r_ram_we   <= 1'b0;
          r_ready    <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = r_ready;
  assign resp_valid_o = r_resp_vld;
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;
  assign ram_we_o     = r_ram_we;
  assign ram_a_o      = r_addr;
  assign ram_wd_o     = r_wd;

endmodule

// File: tb/tb_lsu_rmw.sv
// Purpose: directed bench for lsu_rmw with a byte RAM model and a response scoreboard.
// Latency: n/a.
// Backpressure: requests wait for req_ready_o with a bounded cycle budget.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_we;
  logic [31:0] ram_a;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;

  always #5 clk = ~clk;

  lsu_rmw #(.WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_f3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .ram_we_o     (ram_we),
    .ram_a_o      (ram_a),
    .ram_wd_o     (ram_wd),
    .ram_rd_i     (ram_rd)
  );

  // 128 KiB byte RAM; the low 17 address bits wrap.
  logic [7:0] mem [0:131071];

  always_comb begin
    ram_rd = {mem[ram_a[16:0] + 17'd3], mem[ram_a[16:0] + 17'd2],
              mem[ram_a[16:0] + 17'd1], mem[ram_a[16:0]]};
  end

  always @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        mem[ram_a[16:0] + 17'(i)] <= ram_wd[8*i +: 8];
      end
    end
  end

  function automatic logic [31:0] mword(input logic [16:0] a);
    return {mem[a + 17'd3], mem[a + 17'd2], mem[a + 17'd1], mem[a]};
  endfunction

  task automatic set_word(input logic [16:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 17'(i)] = w[8*i +: 8];
  endtask

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int   cyc      = 0;
  int   we_cnt   = 0;
  int   we_cyc   = -1;
  int   resp_cnt = 0;
  bit   rmw_chk  = 1'b0;
  logic [31:0] prev_a = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: RAM write activity and response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt++;
      we_cyc = cyc;
      if (rmw_chk) chk("rmw_same_addr", ram_a, prev_a);
    end
    if (resp_valid) begin
      resp_cnt++;
      chk("resp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_cycle", cyc, e.cyc);
      end
    end
    prev_a = ram_a;
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // Drives one request at a negedge; the acceptance edge is the next posedge,
  // so "cycle k" of the request is observed when cyc == c + k.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input int lat, input bit push, output int c);
    exp_t e;
    wait_ready();
    req_valid = 1'b1;
    req_we    = we;
    req_f3    = f3;
    req_addr  = addr;
    req_wdata = wdata;
    c = cyc;
    if (push) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = c + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_low_after_accept", 32'(req_ready), 32'd0);
  endtask

  initial begin
    int c;
    int w0;
    int r0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_f3    = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wd", ram_wd, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Loads from 80 7F 01 FF at 0x100.
    set_word(17'h100, 32'hFF017F80);
    do_req(1'b0, 3'b000, 32'h100, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b1, c);
    do_req(1'b0, 3'b100, 32'h100, 32'h0, 32'h00000080, 1'b0, 2, 1'b1, c);
    do_req(1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFFFF01, 1'b0, 2, 1'b1, c);
    do_req(1'b0, 3'b101, 32'h100, 32'h0, 32'h00007F80, 1'b0, 2, 1'b1, c);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hFF017F80, 1'b0, 2, 1'b1, c);
    // Upper address bits are ignored by the 128 KiB RAM.
    do_req(1'b0, 3'b010, 32'h00020100, 32'h0, 32'hFF017F80, 1'b0, 2, 1'b1, c);

    // SW then read back.
    wait_ready();
    w0 = we_cnt;
    do_req(1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, c);
    wait_ready();
    chk("sw_we_count", we_cnt - w0, 1);
    chk("sw_we_cycle", we_cyc, c + 1);
    do_req(1'b0, 3'b010, 32'h200, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, c);

    // SB / SH read-modify-write.
    set_word(17'h300, 32'h11223344);
    rmw_chk = 1'b1;
    w0 = we_cnt;
    do_req(1'b1, 3'b000, 32'h300, 32'h000000AA, 32'h0, 1'b0, 3, 1'b1, c);
    wait_ready();
    chk("sb_we_count", we_cnt - w0, 1);
    chk("sb_we_cycle", we_cyc, c + 2);
    chk("sb_word", mword(17'h300), 32'h112233AA);
    do_req(1'b1, 3'b001, 32'h300, 32'h00005566, 32'h0, 1'b0, 3, 1'b1, c);
    wait_ready();
    chk("sh_word", mword(17'h300), 32'h11225566);
    rmw_chk = 1'b0;

    // Misaligned word load.
    w0 = we_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b1, c);
`else
    do_req(1'b0, 3'b010, 32'h101, 32'h0, 32'h00FF017F, 1'b0, 2, 1'b1, c);
`endif
    wait_ready();
    chk("misalign_no_write", we_cnt - w0, 0);

    // Illegal funct3 encodings.
    w0 = we_cnt;
    do_req(1'b1, 3'b011, 32'h200, 32'h12345678, 32'h0, 1'b1, 1, 1'b1, c);
    do_req(1'b1, 3'b100, 32'h200, 32'h12345678, 32'h0, 1'b1, 1, 1'b1, c);
    do_req(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b1, c);
    wait_ready();
    chk("illegal_no_write", we_cnt - w0, 0);
    chk("illegal_mem_intact", mword(17'h200), 32'hDEADBEEF);

    // Reset during RMW_RD of an SB aborts without write or response.
    set_word(17'h400, 32'hCAFEF00D);
    w0 = we_cnt;
    r0 = resp_cnt;
    do_req(1'b1, 3'b000, 32'h400, 32'h00000055, 32'h0, 1'b0, 3, 1'b0, c);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_ram_we", 32'(ram_we), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_ram_a", ram_a, 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_word", mword(17'h400), 32'hCAFEF00D);
    chk("abort_no_write", we_cnt - w0, 0);
    chk("abort_no_resp", resp_cnt - r0, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
